hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives the go (load-enable) and clear (bubble-insert) inputs of the PC register and of the IF_ID, ID_EXE, EXE_MEM and MEM_WB buffers.
- Detects load-use hazards and taken-branch flushes, and implements syscall halt/resume.
- Counts stall, flush and halted cycles for the board display.

Parameters:
- CNT_W, 16, width of each performance counter.
- LW_OP, 6'h23, opcode treated as a load.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_instruction  in  32  instruction word held in IF_ID (decode stage)
- exe_instruction  in  32  instruction_out of ID_EXE (execute stage)
- branch_taken  in  1  EXE-stage branch/jump resolved taken this cycle
- halt_req  in  1  EXE-stage syscall requesting halt
- resume  in  1  single-cycle resume pulse (debounced externally)
- pc_go  out  1  PC register load enable
- if_id_go  out  1  IF_ID go
- if_id_clear  out  1  IF_ID clear
- id_exe_go  out  1  ID_EXE go
- id_exe_clear  out  1  ID_EXE clear
- exe_mem_go  out  1  EXE_MEM go
- mem_wb_go  out  1  MEM_WB go
- halted  out  1  high while in HALT state
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  branch flush events
- halt_cnt  out  CNT_W  cycles spent in HALT

Behaviour:
- State machine has three states: RUN, HALT and DRAIN. Reset state is RUN. State is registered; all go/clear outputs are combinational from state and inputs.
- While rst is high:
  - every go and clear output is 0;
  - halted is 0;
  - all counters are 0.
  - Reset asserted mid-halt returns the block to RUN.
- Load-use hazard (lu) is asserted when all of the following hold:
  - exe_instruction[31:26]==LW_OP;
  - rt_e = exe_instruction[20:16] is non-zero;
  - ID reads that register, where ID reads rs ([25:21]) unless the opcode is 02 or 03, and ID reads rt ([20:16]) only for opcodes 00, 04, 05 or 2B.
- RUN state outputs, default (no hazard): all go=1, all clear=0.
- RUN state outputs by priority, highest first:
  1. halt_req=1: all go=0 and all clear=0 this cycle; next state HALT.
  2. branch_taken=1: all go=1, if_id_clear=1, id_exe_clear=1. flush_cnt increments. lu is ignored in this cycle.
  3. lu=1: pc_go=0, if_id_go=0, id_exe_go=1, id_exe_clear=1, exe_mem_go=1, mem_wb_go=1. This inserts exactly one bubble. stall_cnt increments.
- HALT state:
  - all go=0, all clear=0, halted=1;
  - halt_cnt increments each cycle;
  - on resume=1, next state is DRAIN; otherwise stay in HALT.
- DRAIN state lasts one cycle:
  - all go=1, clears 0;
  - halt_req is ignored, so the syscall leaves EXE;
  - next state RUN.
  - branch_taken and lu are evaluated in DRAIN exactly as in RUN priorities 2 and 3.
- resume is ignored in RUN and DRAIN.
- All counters wrap modulo 2^CNT_W, with no saturation.
- Latency: hazard response is zero-cycle (combinational) relative to the EXE contents; the stall lasts exactly one cycle because the load advances to MEM.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs immediately 0. Release -> RUN with all go=1, counters 0.
- Load-use, rs match: exe=LW $8,0($0) (0x8C080000), id=ADD $9,$8,$0 (0x01004820) -> one cycle with pc_go=0, if_id_go=0, id_exe_clear=1; stall_cnt=1. Repeat with exe rt=$0 -> no stall.
- Load-use, rt-only case: id=ORI rt=$8 (opcode 0D) using rs=$1 against LW $8 -> no stall. id=SW (2B) with rt=$8 -> stall.
- Branch priority: branch_taken=1 together with a load-use match -> if_id_clear=1, id_exe_clear=1, pc_go=1; flush_cnt=1, stall_cnt unchanged.
- Halt/resume: pulse halt_req -> HALT for 10 cycles with halted=1, all go=0, halt_cnt=10. Pulse resume -> one DRAIN cycle with all go=1 even though halt_req is still high -> then RUN.
- Wrap: CNT_W=4, force 17 flushes -> flush_cnt=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Purpose: sequences the 5-stage pipeline (go/clear per stage) for load-use stalls, branch flushes and syscall halt.
// Latency: zero-cycle, go/clear are combinational from state and EXE/ID contents; counters update on the clock.
// Backpressure: a load-use stall freezes PC and IF_ID for one cycle; HALT freezes every stage until resume.
module hazard_ctrl #(
   parameter int         CNT_W = 16,
   parameter logic [5:0] LW_OP = 6'h23
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      id_instruction,
   input  logic [31:0]      exe_instruction,
   input  logic             branch_taken,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_go,
   output logic             if_id_go,
   output logic             if_id_clear,
   output logic             id_exe_go,
   output logic             id_exe_clear,
   output logic             exe_mem_go,
   output logic             mem_wb_go,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] halt_cnt
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_HALT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [5:0] op_d;
   logic [4:0] rs_d, rt_d, rt_e;
   logic       reads_rs, reads_rt, lu;
   logic       stall_inc, flush_inc, halt_inc;
   logic       unused_bits;

   assign op_d = id_instruction[31:26];
   assign rs_d = id_instruction[25:21];
   assign rt_d = id_instruction[20:16];
   assign rt_e = exe_instruction[20:16];

   // Jumps (J/JAL) carry no rs field; only R-type, BEQ/BNE and SW read rt as a source.
   assign reads_rs = !(op_d == 6'h02 || op_d == 6'h03);
   assign reads_rt = (op_d == 6'h00) || (op_d == 6'h04) || (op_d == 6'h05) || (op_d == 6'h2B);

   // A load to $0 never creates a dependency since $0 is hardwired.
   assign lu = (exe_instruction[31:26] == LW_OP) && (rt_e != 5'd0) &&
               ((reads_rs && rs_d == rt_e) || (reads_rt && rt_d == rt_e));

   assign unused_bits = ^{id_instruction[15:0], exe_instruction[25:21], exe_instruction[15:0]};

   // State register; reset drops a halted core straight back to RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_RUN;
      else     state <= state_nxt;
   end

   // Next state and stage controls; everything held at 0 while rst is high.
   always_comb begin
      state_nxt    = state;
      pc_go        = 1'b0;
      if_id_go     = 1'b0;
      if_id_clear  = 1'b0;
      id_exe_go    = 1'b0;
      id_exe_clear = 1'b0;
      exe_mem_go   = 1'b0;
      mem_wb_go    = 1'b0;
      halted       = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      halt_inc     = 1'b0;
      if (!rst) begin
         case (state)
            S_HALT: begin
               halted   = 1'b1;
               halt_inc = 1'b1;
               if (resume) state_nxt = S_DRAIN;
            end
            default: begin
               // DRAIN ignores halt_req so the syscall that halted us can leave EXE.
               if (state == S_RUN && halt_req) begin
                  state_nxt = S_HALT;
               end else begin
                  state_nxt  = S_RUN;
                  pc_go      = 1'b1;
                  if_id_go   = 1'b1;
                  id_exe_go  = 1'b1;
                  exe_mem_go = 1'b1;
                  mem_wb_go  = 1'b1;
                  if (branch_taken) begin
                     // Flush the two wrong-path instructions; lu is moot since ID is discarded.
                     if_id_clear  = 1'b1;
                     id_exe_clear = 1'b1;
                     flush_inc    = 1'b1;
                  end else if (lu) begin
                     // Hold PC/IF_ID and bubble ID_EXE; one cycle suffices as the load moves to MEM.
                     pc_go        = 1'b0;
                     if_id_go     = 1'b0;
                     id_exe_clear = 1'b1;
                     stall_inc    = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Performance counters, free-running and wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         halt_cnt  <= '0;
      end else begin
         if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
         if (halt_inc)  halt_cnt  <= halt_cnt + CNT_W'(1);
      end
   end

endmodule
